// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared state encoding and digit constants for the stopwatch counting stage
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_e;

  localparam int NUM_DIGITS = 4;
  localparam int BCD_W      = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - two-flop synchronizer, level debouncer and one-cycle press pulse
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_raw_i,
  output logic press_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          deb_q;
  logic          deb_d;
  logic          deb_prev_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // The counter only runs while the synchronized level disagrees with the accepted one.
  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    if (sync2_q != deb_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        deb_d = ~deb_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      deb_q      <= 1'b0;
      deb_prev_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      sync1_q    <= btn_raw_i;
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      cnt_q      <= cnt_d;
    end
  end

  assign press_o = deb_q & ~deb_prev_q;

endmodule

// File: rtl/stopwatch_bcd_core.sv
// rtl/stopwatch_bcd_core.sv - button-driven IDLE/RUN/PAUSE stopwatch with prescaler and 4-digit BCD count
module stopwatch_bcd_core
  import stopwatch_pkg::*;
#(
  parameter int CLK_FREQ        = 100_000_000,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        btn_start_stop,
  input  logic        btn_clear,
  output logic [15:0] bcd,
  output logic        running,
  output logic        rollover
);

  localparam int PW = $clog2(CLK_FREQ);
  localparam int CNT_W = NUM_DIGITS * BCD_W;

  logic             start_pulse;
  logic             clear_pulse;
  state_e           state_q;
  state_e           state_d;
  logic [PW-1:0]    presc_q;
  logic [PW-1:0]    presc_d;
  logic             tick;
  logic [CNT_W-1:0] bcd_q;
  logic [CNT_W-1:0] bcd_d;
  logic             roll_q;
  logic             roll_d;
  logic             carry;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_start (
    .clk      (clk),
    .reset_n  (reset_n),
    .btn_raw_i(btn_start_stop),
    .press_o  (start_pulse)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clear (
    .clk      (clk),
    .reset_n  (reset_n),
    .btn_raw_i(btn_clear),
    .press_o  (clear_pulse)
  );

  // Clear beats start when stopped; in RUN clear is ignored so start always wins there.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start_pulse && !clear_pulse) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (start_pulse) state_d = ST_PAUSE;
      end
      ST_PAUSE: begin
        if (clear_pulse)      state_d = ST_IDLE;
        else if (start_pulse) state_d = ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign tick = (state_q == ST_RUN) && (presc_q == PW'(CLK_FREQ - 1));

  always_comb begin
    presc_d = presc_q;
    if (state_d == ST_IDLE) begin
      presc_d = '0;
    end else if (state_q == ST_RUN) begin
      presc_d = tick ? '0 : presc_q + 1'b1;
    end
  end

  // Ripple the tick through the digits; a carry out of the top digit is the wrap.
  always_comb begin
    bcd_d = bcd_q;
    carry = tick;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (carry) begin
        if (bcd_q[i*BCD_W +: BCD_W] >= BCD_MAX) begin
          bcd_d[i*BCD_W +: BCD_W] = '0;
        end else begin
          bcd_d[i*BCD_W +: BCD_W] = bcd_q[i*BCD_W +: BCD_W] + 1'b1;
          carry = 1'b0;
        end
      end
    end
    roll_d = carry;
    if (state_d == ST_IDLE) begin
      bcd_d  = '0;
      roll_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      presc_q <= '0;
      bcd_q   <= '0;
      roll_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      bcd_q   <= bcd_d;
      roll_q  <= roll_d;
    end
  end

  assign bcd      = bcd_q;
  assign running  = (state_q == ST_RUN);
  assign rollover = roll_q;

endmodule

// File: tb/tb_stopwatch_bcd_core.sv
// tb/tb_stopwatch_bcd_core.sv - scoreboard bench for the stopwatch counting stage
module tb_stopwatch_bcd_core;

  typedef struct {
    logic [15:0] val;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        reset2_n = 1'b0;
  logic        start = 1'b0;
  logic        clear = 1'b0;
  logic        start2 = 1'b0;
  logic        clear2 = 1'b0;
  logic [15:0] bcd;
  logic [15:0] bcd2;
  logic        running;
  logic        running2;
  logic        rollover;
  logic        rollover2;

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   roll1_cnt = 0;
  int   roll2_cnt = 0;
  bit   mon_en = 1'b0;
  bit   done2 = 1'b0;
  exp_t sb_q[$];

  stopwatch_bcd_core #(.CLK_FREQ(10), .DEBOUNCE_CYCLES(4)) u_dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .btn_start_stop(start),
    .btn_clear     (clear),
    .bcd           (bcd),
    .running       (running),
    .rollover      (rollover)
  );

  stopwatch_bcd_core #(.CLK_FREQ(2), .DEBOUNCE_CYCLES(1)) u_dut_fast (
    .clk           (clk),
    .reset_n       (reset2_n),
    .btn_start_stop(start2),
    .btn_clear     (clear2),
    .bcd           (bcd2),
    .running       (running2),
    .rollover      (rollover2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_neg(input int c);
    wait_cyc(c);
    @(negedge clk);
  endtask

  function automatic logic [15:0] to_bcd(input int n);
    logic [3:0] d0, d1, d2, d3;
    d0 = 4'(n % 10);
    d1 = 4'((n / 10) % 10);
    d2 = 4'((n / 100) % 10);
    d3 = 4'((n / 1000) % 10);
    return {d3, d2, d1, d0};
  endfunction

  task automatic push_exp(input logic [15:0] v, input int c);
    exp_t e;
    e.val = v;
    e.cyc = c;
    sb_q.push_back(e);
  endtask

  task automatic push_counts(input int first_dec, input int first_cyc, input int n);
    for (int j = 0; j < n; j++) push_exp(to_bcd((first_dec + j) % 10000), first_cyc + 10 * j);
  endtask

  // Scoreboard monitor for the slow instance: every bcd change must match the next expectation.
  initial begin
    logic [15:0] prev;
    exp_t        e;
    prev = 16'h0000;
    forever begin
      @(negedge clk);
      if (rollover) roll1_cnt++;
      if (mon_en && bcd !== prev) begin
        if (sb_q.size() == 0) begin
          check("sb_unexpected", {16'h0, bcd}, {16'h0, prev});
        end else begin
          e = sb_q.pop_front();
          check("sb_val", {16'h0, bcd}, {16'h0, e.val});
          check("sb_cyc", cyc, e.cyc);
        end
        prev = bcd;
      end
    end
  end

  initial begin
    logic [15:0] prev2;
    prev2 = 16'h0000;
    forever begin
      @(negedge clk);
      if (rollover2) roll2_cnt++;
      if (mon_en && bcd2 !== prev2) begin
        for (int i = 0; i < 4; i++) check("fast_nibble_le9", {31'h0, (bcd2[i*4 +: 4] <= 4'd9)}, 32'h1);
        prev2 = bcd2;
      end
    end
  end

  // Fast instance: run straight through 9999 -> 0000.
  initial begin
    wait_cyc(3);
    @(negedge clk);
    reset2_n = 1'b1;
    wait_cyc(10);
    start2 = 1'b1;
    wait_cyc(13);
    start2 = 1'b0;
    @(negedge clk);
    check("fast_run_before", {31'h0, running2}, 32'h0);
    wait_neg(14);
    check("fast_run_rise", {31'h0, running2}, 32'h1);
    wait_neg(20010);
    check("fast_9998", {16'h0, bcd2}, {16'h0, to_bcd(9998)});
    wait_neg(20012);
    check("fast_9999", {16'h0, bcd2}, {16'h0, to_bcd(9999)});
    check("fast_roll_low", {31'h0, rollover2}, 32'h0);
    wait_neg(20014);
    check("fast_wrap_val", {16'h0, bcd2}, 32'h0);
    check("fast_roll_high", {31'h0, rollover2}, 32'h1);
    check("fast_run_kept", {31'h0, running2}, 32'h1);
    wait_neg(20015);
    check("fast_roll_1cyc", {31'h0, rollover2}, 32'h0);
    check("fast_after_wrap", {16'h0, bcd2}, 32'h0);
    check("fast_run_still", {31'h0, running2}, 32'h1);
    done2 = 1'b1;
  end

  initial begin
    wait_neg(3);
    check("rst_bcd", {16'h0, bcd}, 32'h0);
    check("rst_running", {31'h0, running}, 32'h0);
    check("rst_rollover", {31'h0, rollover}, 32'h0);
    check("rst_fast_bcd", {16'h0, bcd2}, 32'h0);
    reset_n = 1'b1;
    mon_en  = 1'b1;
    wait_neg(203);
    check("idle_bcd", {16'h0, bcd}, 32'h0);
    check("idle_running", {31'h0, running}, 32'h0);
    check("idle_rollover", {31'h0, rollover}, 32'h0);

    // Count: press at 210, RUN at 217, one increment every 10 cycles.
    wait_cyc(210);
    start = 1'b1;
    push_counts(1, 227, 15);
    wait_neg(216);
    check("press_lat_before", {31'h0, running}, 32'h0);
    wait_neg(217);
    check("press_lat_rise", {31'h0, running}, 32'h1);
    wait_cyc(218);
    start = 1'b0;

    wait_cyc(260);
    clear = 1'b1;
    wait_cyc(266);
    clear = 1'b0;
    wait_neg(275);
    check("clear_in_run_ignored", {31'h0, running}, 32'h1);

    wait_neg(367);
    check("count_0015", {16'h0, bcd}, 32'h0015);
    start = 1'b1;
    wait_cyc(373);
    start = 1'b0;
    wait_neg(374);
    check("pause_running", {31'h0, running}, 32'h0);
    wait_neg(499);
    check("pause_hold", {16'h0, bcd}, 32'h0015);

    wait_cyc(500);
    clear = 1'b1;
    push_exp(16'h0000, 507);
    wait_cyc(506);
    clear = 1'b0;
    wait_neg(507);
    check("clear_pause_bcd", {16'h0, bcd}, 32'h0);
    check("clear_pause_run", {31'h0, running}, 32'h0);

    wait_cyc(520);
    start = 1'b1;
    wait_cyc(523);
    start = 1'b0;
    wait_neg(540);
    check("glitch_rejected", {31'h0, running}, 32'h0);

    // Pause at bcd=3 with prescaler 7, resume: next increment 3 cycles later.
    wait_cyc(550);
    start = 1'b1;
    push_counts(1, 567, 3);
    wait_cyc(556);
    start = 1'b0;
    wait_neg(557);
    check("run2_rise", {31'h0, running}, 32'h1);
    wait_cyc(587);
    start = 1'b1;
    wait_cyc(593);
    start = 1'b0;
    wait_neg(594);
    check("pause2_running", {31'h0, running}, 32'h0);
    check("pause2_bcd", {16'h0, bcd}, 32'h0003);
    wait_neg(694);
    check("pause2_hold100", {16'h0, bcd}, 32'h0003);
    wait_cyc(700);
    start = 1'b1;
    push_counts(4, 710, 6);
    wait_cyc(706);
    start = 1'b0;
    wait_neg(707);
    check("resume_running", {31'h0, running}, 32'h1);
    wait_neg(709);
    check("resume_not_yet", {16'h0, bcd}, 32'h0003);
    wait_neg(710);
    check("resume_first_inc", {16'h0, bcd}, 32'h0004);

    // Start and clear together in RUN: pause, count kept.
    wait_cyc(760);
    start = 1'b1;
    clear = 1'b1;
    wait_cyc(766);
    start = 1'b0;
    clear = 1'b0;
    wait_neg(767);
    check("both_run_pause", {31'h0, running}, 32'h0);
    check("both_run_keep", {16'h0, bcd}, 32'h0009);
    wait_neg(775);
    check("both_run_held", {16'h0, bcd}, 32'h0009);

    wait_cyc(780);
    clear = 1'b1;
    push_exp(16'h0000, 787);
    wait_cyc(786);
    clear = 1'b0;
    wait_neg(787);
    check("clear2_bcd", {16'h0, bcd}, 32'h0);

    // Count to 42 then reset mid-RUN.
    wait_cyc(800);
    start = 1'b1;
    push_counts(1, 817, 42);
    wait_cyc(806);
    start = 1'b0;
    wait_neg(1230);
    check("pre_reset_0042", {16'h0, bcd}, 32'h0042);
    check("pre_reset_run", {31'h0, running}, 32'h1);
    reset_n = 1'b0;
    push_exp(16'h0000, 1231);
    wait_neg(1231);
    check("midrun_reset_bcd", {16'h0, bcd}, 32'h0);
    check("midrun_reset_run", {31'h0, running}, 32'h0);
    check("midrun_reset_roll", {31'h0, rollover}, 32'h0);
    reset_n = 1'b1;
    wait_neg(1300);
    check("post_reset_idle", {16'h0, bcd}, 32'h0);
    check("post_reset_run", {31'h0, running}, 32'h0);

    while (!done2 && cyc < 25000) begin
      @(posedge clk);
      #1;
    end
    check("fast_done", {31'h0, done2}, 32'h1);
    check("sb_drained", sb_q.size(), 0);
    check("slow_no_rollover", roll1_cnt, 0);
    check("fast_one_rollover", roll2_cnt, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/stopwatch_bcd_core.md
# stopwatch_bcd_core

Upstream counting stage for the 4-digit seven-segment display driver. It debounces two push-buttons (start/stop, clear), runs an IDLE/RUN/PAUSE state machine, divides the system clock to a count tick, and keeps a 4-digit cascaded BCD count. The packed BCD value feeds the display mux/decoder directly, so the display stage no longer needs its own counter.

## Interface
- CLK_FREQ, 100_000_000, clock cycles per count tick; minimum 2
- DEBOUNCE_CYCLES, 1_000_000, consecutive stable cycles required to accept a button level change; minimum 1
- clk  input  1  system clock; all state on the rising edge
- reset_n  input  1  reset, synchronous, active-low
- btn_start_stop  input  1  raw asynchronous button, active-high
- btn_clear  input  1  raw asynchronous button, active-high
- bcd  output  16  packed count, [3:0]=ones … [15:12]=thousands; each nibble 0–9
- running  output  1  high while state is RUN
- rollover  output  1  one-cycle pulse on a 9999→0000 wrap

## Operation
- Each button passes through a 2-flop synchronizer, then a debouncer:
  - The counter increments while the synchronized level differs from the debounced level.
  - The counter clears to 0 while the levels match.
  - When the counter reaches DEBOUNCE_CYCLES, the debounced level flips and the counter clears.
- A press pulse is high for exactly one cycle, in the cycle after the debounced level goes 0→1. Releases produce no pulse.
- State machine states: IDLE, RUN, PAUSE.
  - IDLE + start pulse → RUN.
  - RUN + start pulse → PAUSE.
  - PAUSE + start pulse → RUN.
  - PAUSE + clear pulse → IDLE.
  - IDLE + clear pulse → IDLE (no effect).
  - RUN + clear pulse: ignored.
- Simultaneous start and clear pulses:
  - In IDLE or PAUSE, clear wins.
  - In RUN, start wins (→ PAUSE) and clear is dropped.
- Prescaler runs 0..CLK_FREQ-1:
  - Advances only in RUN. The tick is asserted when prescaler == CLK_FREQ-1, and the prescaler wraps to 0.
  - Held in PAUSE, so the fractional count is kept across a resume.
  - Forced to 0 in IDLE and on the transition into IDLE.
- BCD count:
  - On each tick the ones digit increments. A digit at 9 goes to 0 and carries into the next digit.
  - 9999 + tick → 0000 with rollover high for one cycle; the state stays RUN.
  - Entering IDLE forces bcd to 0000.
  - A nibble never holds a value greater than 9.

## Timing
- Reset (reset_n low at a clock edge) sets: bcd=0000, running=0, rollover=0, state=IDLE, prescaler=0, sync flops=0, debounced levels=0, debounce counters=0, pulses=0.
- Reset asserted mid-RUN or mid-PAUSE takes effect at that edge and discards any partially debounced press.
- Press latency:
  - Raw rise at edge N: synchronized level at N+2, debounced level at N+2+DEBOUNCE_CYCLES, pulse in the next cycle.
  - State and running update at the edge that ends the pulse cycle.
- Count timing:
  - bcd and rollover are registered. They change at the edge where tick is high and are visible in the following cycle.
  - First increment after entering RUN from IDLE comes CLK_FREQ cycles after running rises.
- PAUSE entered at prescaler value p: after resume, the next increment comes CLK_FREQ-p cycles later.
- Tick and start pulse in the same RUN cycle: the increment is applied, then the state becomes PAUSE.
- A raw glitch shorter than DEBOUNCE_CYCLES synchronized cycles produces no pulse.

## Structure
- Shared package stopwatch_pkg:
  - State enum (IDLE, RUN, PAUSE).
  - NUM_DIGITS=4.
  - BCD_W=4.
  - BCD_MAX=4'd9.
- Sub-module btn_debounce:
  - Contains the synchronizer, the debounce counter and the rising-edge pulse.
  - Parameterised by DEBOUNCE_CYCLES.
  - Instantiated twice.
- Top level: FSM, prescaler, BCD cascade (loop over NUM_DIGITS).

## Test plan
All scenarios use CLK_FREQ=10, DEBOUNCE_CYCLES=4, 10 ns clock.
- Reset: hold reset_n low for 3 cycles → bcd=16'h0000, running=0, rollover=0. Release reset and apply no buttons for 200 cycles → values unchanged.
- Count: start held high for 8 cycles → running rises 7 cycles after the raw rise. After 150 further cycles → bcd=16'h0015, with exactly one increment every 10 cycles.
- Glitch rejection: start high for 3 cycles, then low → running stays 0 and no state change occurs.
- Pause/resume:
  - Press start at bcd=0x0003 with prescaler=7 → running=0, bcd holds 0x0003 for 100 cycles.
  - Press start again → bcd=0x0004 exactly 3 cycles after running rises.
- Rollover: count through from 0x9998 → 0x9999 → 0x0000 with rollover high for 1 cycle and running still 1.
- Clear/priority:
  - Clear pressed in RUN → ignored.
  - Start and clear in the same cycle in RUN → PAUSE with the count kept.
  - Clear in PAUSE → IDLE with bcd=0x0000.
  - reset_n low during RUN at bcd=0x0042 → 0x0000 in the next cycle.
